// File: rtl/gaussian_filter_stream.sv
// rtl/gaussian_filter_stream.sv - streaming 3x3 Gaussian filter with two line buffers; GF_RAW_SUM_EN selects raw sums
module gaussian_filter_stream #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int NUM_CH = 3,
    parameter int DATA_W = 8,
`ifdef GF_RAW_SUM_EN
    localparam int OUT_W = DATA_W + 4
`else
    localparam int OUT_W = DATA_W
`endif
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_rgb_vld,
    input  logic [NUM_CH*DATA_W-1:0]  i_rgb_data,
    output logic                      i_rgb_busy,
    output logic                      o_result_vld,
    output logic [NUM_CH*OUT_W-1:0]   o_result_data,
    input  logic                      o_result_busy,
    output logic                      o_frame_done
);

    localparam int PW = NUM_CH * DATA_W;
    localparam int SW = DATA_W + 4;
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 2;

    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic [PW-1:0]           lb0 [IMG_W];
    logic [PW-1:0]           lb1 [IMG_W];
    logic [PW-1:0]           lb0_rd, lb1_rd;
    logic [PW-1:0]           win_q [3][3];
    logic [PW-1:0]           win_d [3][3];
    logic                    s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic                    res_vld_q, res_vld_d, res_last_q, res_last_d;
    logic [NUM_CH*OUT_W-1:0] res_q, res_d, res_calc;
    logic [SW-1:0]           sum_c [NUM_CH];
    logic [SW-1:0]           rnd_c [NUM_CH];
    logic                    stall, accept;

    // A result held at the output freezes the whole pipeline and back-pressures the source
    assign stall      = res_vld_q && o_result_busy;
    assign accept     = i_rgb_vld && !stall;
    assign i_rgb_busy = stall;

    assign lb0_rd = lb0[col_q];
    assign lb1_rd = lb1[col_q];

    // Raster counters, window shift and S1 valid tracking
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        win_d     = win_q;
        s1_vld_d  = s1_vld_q;
        s1_last_d = s1_last_q;
        if (!stall) begin
            s1_vld_d  = 1'b0;
            s1_last_d = 1'b0;
        end
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = i_rgb_data;
            s1_vld_d    = (col_q >= CW'(2)) && (row_q >= RW'(2));
            s1_last_d   = (col_q == CW'(IMG_W-1)) && (row_q == RW'(IMG_H-1));
            if (col_q == CW'(IMG_W-1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H-1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Kernel [1 2 1; 2 4 2; 1 2 1] per channel; weights are powers of two so shifts suffice
    always_comb begin
        res_calc = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            sum_c[ch] = '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    sum_c[ch] = sum_c[ch] +
                        (SW'(win_q[r][c][ch*DATA_W +: DATA_W]) << ((r == 1 ? 1 : 0) + (c == 1 ? 1 : 0)));
                end
            end
            rnd_c[ch] = sum_c[ch] + SW'(8);
`ifdef GF_RAW_SUM_EN
            res_calc[ch*OUT_W +: OUT_W] = sum_c[ch];
`else
            res_calc[ch*OUT_W +: OUT_W] = rnd_c[ch][SW-1:4];
`endif
        end
    end

    // S2 loads from S1 whenever the output is free; a transfer and a load may share a cycle
    always_comb begin
        res_vld_d  = res_vld_q;
        res_last_d = res_last_q;
        res_d      = res_q;
        if (!stall) begin
            res_vld_d  = s1_vld_q;
            res_last_d = s1_last_q;
            if (s1_vld_q) begin
                res_d = res_calc;
            end
        end
    end

    // Pipeline and counter state
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            col_q      <= '0;
            row_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            res_vld_q  <= 1'b0;
            res_last_q <= 1'b0;
            res_q      <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            s1_vld_q   <= s1_vld_d;
            s1_last_q  <= s1_last_d;
            res_vld_q  <= res_vld_d;
            res_last_q <= res_last_d;
            res_q      <= res_d;
            win_q      <= win_d;
        end
    end

    // Line buffers are plain RAM; stale content is masked by the row/col validity gate
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb1[col_q] <= lb0[col_q];
            lb0[col_q] <= i_rgb_data;
        end
    end

    assign o_result_vld  = res_vld_q;
    assign o_result_data = res_q;
    assign o_frame_done  = res_vld_q && !o_result_busy && res_last_q;

endmodule
